bytes2bits_stream_ctrl: RTL
===========================

// Module: bytes2bits_stream_ctrl
// PURPOSE
//   Sequencer around the bytes2bits packer for ByteDecode-style unpacking.
//   - Collects N_BYTES bytes from a byte stream and packs them LSB-first through an internal bytes2bits instance.
//   - Emits the packed word as D-bit fields over a valid/ready handshake.
//   - Repeats for N_BLOCKS blocks per start_i and pulses done_o after the last field.
// PARAMETERS
//   N_BYTES   4  bytes per block; width of the bytes2bits instance
//   D         4  output field width in bits; (N_BYTES*8) % D == 0 is required (elaboration $error otherwise)
//   N_BLOCKS  2  blocks processed per start_i; must be >= 1
// PORTS
//   clk_i          in   1          clock; all state updates on the rising edge
//   rst_i          in   1          synchronous active-high reset
//   start_i        in   1          begin a job; honoured only in IDLE
//   byte_valid_i   in   1          byte_i is valid
//   byte_i         in   8          input byte
//   byte_ready_o   out  1          controller accepts byte_i this cycle
//   coef_valid_o   out  1          coef_o is valid
//   coef_o         out  D          current field
//   coef_ready_i   in   1          downstream accepts coef_o
//   busy_o         out  1          high in every state except IDLE
//   done_o         out  1          one-cycle pulse at job end
// BEHAVIOUR
//   - Reset (rst_i=1 at the clock edge): state=IDLE; all outputs 0; byte, field and block counters cleared.
//     Reset mid-job discards partial bytes and buffered words; no done_o is generated.
//   - Constants: C = N_BYTES*8/D fields per block.
//     Byte k of a block lands at word[8k+:8] (bytes2bits order).
//     Field j = word[j*D+:D], emitted in order j=0..C-1.
//   - FSM states: IDLE, LOAD, EMIT, DONE.
//   - IDLE: start_i=1 -> LOAD; block count=0. start_i is ignored in all other states.
//   - LOAD
//     - byte_ready_o=1.
//     - Accept on byte_valid_i & byte_ready_o: store into byte slot [cnt]; cnt++.
//     - The cycle that accepts byte N_BYTES-1: word register <= bytes2bits output with that byte included; next state EMIT.
//     - First coef_valid_o is high the cycle after the N-th byte handshake (latency 1).
//   - EMIT
//     - coef_valid_o=1; coef_o is driven from the registered word and field counter (no combinational path from inputs).
//     - coef_o is held stable while coef_ready_i=0.
//     - On handshake: field++.
//     - On handshake of field C-1:
//       - block++; if block == N_BLOCKS-1 -> DONE;
//       - else -> LOAD (or prefetch path, see CONFIGURATION).
//   - DONE: done_o=1 for exactly one cycle; busy_o=1; next state IDLE.
//   - byte_valid_i without byte_ready_o is ignored; no byte is lost or double-counted.
//   - Counter widths are $clog2 of the respective maxima, each at least 1 bit.
//     Counters wrap to 0 at block boundaries only.
// CONFIGURATION
//   B2B_CTRL_PREFETCH_EN defined:
//     - A second N_BYTES buffer is added.
//     - In EMIT, byte_ready_o=1 while the prefetch buffer is not full and a further block remains in the job.
//     - At the last-field handshake:
//       - prefetch full -> word <= packed prefetch, stay in EMIT, field=0 (zero-bubble, coef_valid_o stays 1);
//       - else -> LOAD, with already-prefetched bytes retained and the byte count carried over.
//     - A byte accepted in the same cycle as the last-field handshake counts toward the prefetch buffer.
//       If it completes the buffer, the zero-bubble path is taken.
//   B2B_CTRL_PREFETCH_EN not defined:
//     - Single buffer; byte_ready_o=0 in EMIT.
//     - Each block incurs a LOAD phase of at least N_BYTES cycles.
// TESTING (defaults N_BYTES=4, D=4, N_BLOCKS=2 unless noted)
//   1. start; bytes EF,CD,AB,89 then 00,00,00,00; ready=1
//      -> coef_o F,E,D,C,B,A,9,8, then 0 x8; done_o pulses once; busy_o falls the cycle after.
//   2. Toggle coef_ready_i 1010..., byte_valid_i with gaps
//      -> identical field sequence; coef_o stable during stalls; no drops or duplicates.
//   3. rst_i=1 for 1 cycle after 2 bytes of block 0; restart with FF x8
//      -> all outputs 0 after reset; 16 fields of F; no stale data; single done_o.
//   4. start_i held high through the whole job
//      -> only one job runs; done_o exactly once; next start_i in IDLE begins a new job.
//   5. D=8, N_BYTES=4: bytes 00,01,02,03 -> coef_o 00,01,02,03 (byte-identity).
//   6. PREFETCH_EN with bytes streamed continuously and ready=1
//      -> coef_valid_o never drops between block 0 field 7 and block 1 field 0.
//      Without the macro: byte_ready_o=0 throughout EMIT.

Source files
------------

// File: rtl/bytes2bits_stream_ctrl.sv
// -----------------------------------------------------------------------------
// bytes2bits_stream_ctrl
//   Sequencer around the bytes2bits packer for ByteDecode-style unpacking.
//   Collects N_BYTES bytes, packs them LSB-first (byte k -> word[8k+:8]), then
//   emits the packed word as C = N_BYTES*8/D fields of D bits, field 0 first,
//   over a valid/ready handshake. Repeats for N_BLOCKS blocks per start_i and
//   pulses done_o once after the last field of the job.
//
// Optional feature macro: B2B_CTRL_PREFETCH_EN
//   Defined     : a second N_BYTES buffer collects the next block during EMIT,
//                 giving a zero-bubble block switch when it is already full.
//   Not defined : single buffer; byte_ready_o is low throughout EMIT.
//
// Ports
//   clk_i         in   1   clock, rising edge
//   rst_i         in   1   synchronous active-high reset
//   start_i       in   1   begin a job (honoured only in IDLE)
//   byte_valid_i  in   1   byte_i is valid
//   byte_i        in   8   input byte
//   byte_ready_o  out  1   controller accepts byte_i this cycle
//   coef_valid_o  out  1   coef_o is valid
//   coef_o        out  D   current field
//   coef_ready_i  in   1   downstream accepts coef_o
//   busy_o        out  1   high in every state except IDLE
//   done_o        out  1   one-cycle pulse at job end
// -----------------------------------------------------------------------------

// Byte-vector to bit-vector packer: byte k lands at bit_vec[8k+:8].
module bytes2bits #(
  parameter int N_BYTES = 4
) (
  input  logic [N_BYTES-1:0][7:0] byte_vec,
  output logic [N_BYTES*8-1:0]    bit_vec
);
  // Packed-array layout already places element k at bits [8k+:8].
  assign bit_vec = byte_vec;
endmodule

module bytes2bits_stream_ctrl #(
  parameter int N_BYTES  = 4,
  parameter int D        = 4,
  parameter int N_BLOCKS = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         byte_valid_i,
  input  logic [7:0]   byte_i,
  output logic         byte_ready_o,
  output logic         coef_valid_o,
  output logic [D-1:0] coef_o,
  input  logic         coef_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  localparam int W     = N_BYTES * 8;
  localparam int C     = W / D;
  localparam int CNT_W = (N_BYTES  > 1) ? $clog2(N_BYTES)  : 1;
  localparam int FLD_W = (C        > 1) ? $clog2(C)        : 1;
  localparam int BLK_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;

  if ((N_BYTES * 8) % D != 0) begin : g_bad_d
    $error("bytes2bits_stream_ctrl: N_BYTES*8 (%0d) is not a multiple of D (%0d)", W, D);
  end
  if (N_BLOCKS < 1) begin : g_bad_blocks
    $error("bytes2bits_stream_ctrl: N_BLOCKS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_e;

  state_e state_q, state_d;

  logic [N_BYTES-1:0][7:0] byte_buf_q;
  logic [N_BYTES-1:0][7:0] load_buf;
  logic [N_BYTES-1:0][7:0] b2b_in;
  logic [W-1:0]            packed_word;
  logic [W-1:0]            word_q;
  logic [CNT_W-1:0]        byte_cnt_q;
  logic [FLD_W-1:0]        field_cnt_q;
  logic [BLK_W-1:0]        block_cnt_q;

  logic byte_take, coef_take;
  logic last_byte, last_field, last_block;

  assign last_byte  = (byte_cnt_q  == CNT_W'(N_BYTES - 1));
  assign last_field = (field_cnt_q == FLD_W'(C - 1));
  assign last_block = (block_cnt_q == BLK_W'(N_BLOCKS - 1));

`ifdef B2B_CTRL_PREFETCH_EN
  logic [N_BYTES-1:0][7:0] pf_buf_q;
  logic [N_BYTES-1:0][7:0] pf_load_buf;
  logic [CNT_W-1:0]        pf_cnt_q;
  logic                    pf_full_q;
  logic                    pf_complete;

  // Prefetch only while there is room and the job still has another block.
  assign byte_ready_o = (state_q == LOAD) ||
                        ((state_q == EMIT) && !pf_full_q && !last_block);

  // Next block is ready either from earlier cycles or by the byte taken now.
  assign pf_complete = pf_full_q ||
                       ((state_q == EMIT) && byte_take && (pf_cnt_q == CNT_W'(N_BYTES - 1)));

  always_comb begin
    pf_load_buf           = pf_buf_q;
    pf_load_buf[pf_cnt_q] = byte_i;
  end

  assign b2b_in = (state_q == EMIT) ? pf_load_buf : load_buf;
`else
  assign byte_ready_o = (state_q == LOAD);
  assign b2b_in       = load_buf;
`endif

  assign coef_valid_o = (state_q == EMIT);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign byte_take    = byte_valid_i && byte_ready_o;
  assign coef_take    = coef_valid_o && coef_ready_i;

  // Field select comes only from registers, so coef_o is stable during stalls.
  assign coef_o = coef_valid_o ? word_q[int'(field_cnt_q) * D +: D] : '0;

  // Byte buffer with the incoming byte merged into its slot, so the word can
  // be captured in the same cycle the final byte is accepted.
  always_comb begin
    load_buf             = byte_buf_q;
    load_buf[byte_cnt_q] = byte_i;
  end

  bytes2bits #(.N_BYTES(N_BYTES)) u_b2b (
    .byte_vec (b2b_in),
    .bit_vec  (packed_word)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: if (byte_take && last_byte) state_d = EMIT;
      EMIT: begin
        if (coef_take && last_field) begin
          if (last_block) begin
            state_d = DONE;
          end else begin
`ifdef B2B_CTRL_PREFETCH_EN
            state_d = pf_complete ? EMIT : LOAD;
`else
            state_d = LOAD;
`endif
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the byte buffers are not reset; every slot is rewritten before the
  // packed word is captured, and clearing the counters discards partial data.
  always_ff @(posedge clk_i) begin
    if (byte_take && (state_q == LOAD)) byte_buf_q <= load_buf;
`ifdef B2B_CTRL_PREFETCH_EN
    if (byte_take && (state_q == EMIT)) pf_buf_q <= pf_load_buf;
    // Bytes prefetched but not yet a full block move to the main buffer.
    if ((state_q == EMIT) && coef_take && last_field && !last_block && !pf_complete)
      byte_buf_q <= pf_load_buf;
`endif
  end

  // ---------------------------------------------------------------------------
  // Counters and word register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_cnt_q  <= '0;
      field_cnt_q <= '0;
      block_cnt_q <= '0;
      word_q      <= '0;
`ifdef B2B_CTRL_PREFETCH_EN
      pf_cnt_q    <= '0;
      pf_full_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            byte_cnt_q  <= '0;
            field_cnt_q <= '0;
            block_cnt_q <= '0;
          end
        end
        LOAD: begin
          if (byte_take) begin
            if (last_byte) begin
              byte_cnt_q  <= '0;
              field_cnt_q <= '0;
              word_q      <= packed_word;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        EMIT: begin
`ifdef B2B_CTRL_PREFETCH_EN
          if (byte_take) begin
            if (pf_cnt_q == CNT_W'(N_BYTES - 1)) begin
              pf_cnt_q  <= '0;
              pf_full_q <= 1'b1;
            end else begin
              pf_cnt_q <= pf_cnt_q + 1'b1;
            end
          end
`endif
          if (coef_take) begin
            if (last_field) begin
              field_cnt_q <= '0;
              block_cnt_q <= last_block ? '0 : block_cnt_q + 1'b1;
`ifdef B2B_CTRL_PREFETCH_EN
              if (!last_block) begin
                pf_cnt_q  <= '0;
                pf_full_q <= 1'b0;
                if (pf_complete) word_q     <= packed_word;
                else             byte_cnt_q <= pf_cnt_q + CNT_W'(byte_take);
              end
`endif
            end else begin
              field_cnt_q <= field_cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
